qe_input_decode: RTL and testbench

//  Front end for the quadrature position counter. Synchronises the raw encoder pins
//  i/q to clk and digitally filters each one. Decodes the 4x Gray-code transitions

---
 rtl/qe_input_decode.sv | 139 +++++++++++++
 tb/tb_qe_input_decode.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/qe_input_decode.sv
// Quadrature encoder front end: per-pin sync + glitch filter, 4x Gray decode into
// up/dn/err pulses, sticky direction, saturating error count and post-reset settle gate.

// Per-channel glitch filter: a new level is accepted after FILT_CNT consecutive differing samples.
module qe_filt #(
  parameter int FILT_CNT = 8,
  parameter int FILT_W   = 4
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic s_i,
  output logic filt_o
);
  logic [FILT_W-1:0] cnt_q, cnt_d;
  logic              filt_q, filt_d;

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (s_i == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == FILT_W'(FILT_CNT - 1)) begin
      filt_d = s_i;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;
endmodule

module qe_input_decode #(
  parameter int FILT_CNT = 8,
  parameter int FILT_W   = 4
) (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       i_i,
  input  logic       q_i,
  input  logic       en_i,
  output logic       up_o,
  output logic       dn_o,
  output logic       err_o,
  output logic       dir_o,
  output logic       ready_o,
  output logic [7:0] err_cnt_o
);
  localparam int NUM_CH = 2;
  localparam int SETTLE = FILT_CNT + 3;
  localparam int SW     = $clog2(SETTLE + 1);

  // Bit 1 carries channel i, bit 0 channel q throughout.
  logic [NUM_CH-1:0] pin, sync1_q, sync2_q, filt, prev_q;
  logic [SW-1:0]     settle_q, settle_d;
  logic              ready_q, ready_d;
  logic              up_q, dn_q, err_q, up_d, dn_d, err_d;
  logic              dir_q, dir_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [1:0]        step;
  logic              go;

  assign pin = {i_i, q_i};

  qe_filt #(.FILT_CNT(FILT_CNT), .FILT_W(FILT_W)) u_filt [NUM_CH-1:0] (
    .clk_i  (clk_i),
    .clr_i  (clr_i),
    .s_i    (sync2_q),
    .filt_o (filt)
  );

  // Position around the Gray cycle 00->10->11->01; the index delta classifies the step.
  function automatic logic [1:0] gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   gidx = 2'd0;
      2'b10:   gidx = 2'd1;
      2'b11:   gidx = 2'd2;
      default: gidx = 2'd3;
    endcase
  endfunction

  always_comb begin
    step      = gidx(filt) - gidx(prev_q);
    go        = ready_q & en_i;
    up_d      = go && (step == 2'd1);
    dn_d      = go && (step == 2'd3);
    err_d     = go && (step == 2'd2);
    dir_d     = dir_q;
    if (up_d) dir_d = 1'b1;
    if (dn_d) dir_d = 1'b0;
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    settle_d  = ready_q ? settle_q : settle_q + 1'b1;
    ready_d   = ready_q | (settle_q == SW'(SETTLE - 1));
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      settle_q  <= '0;
      ready_q   <= 1'b0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      err_q     <= 1'b0;
      dir_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      sync1_q   <= pin;
      sync2_q   <= sync1_q;
      prev_q    <= filt;
      settle_q  <= settle_d;
      ready_q   <= ready_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
      err_q     <= err_d;
      dir_q     <= dir_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign up_o      = up_q;
  assign dn_o      = dn_q;
  assign err_o     = err_q;
  assign dir_o     = dir_q;
  assign ready_o   = ready_q;
  assign err_cnt_o = err_cnt_q;
endmodule

// File: tb/tb_qe_input_decode.sv
// Bench for qe_input_decode: directed scenarios plus random pin/en/clr traffic, every
// cycle checked against an edge-timestamp reference model of the filter/decode rules.
module tb_qe_input_decode;
  localparam int FILT_CNT = 8;
  localparam int SETTLE   = FILT_CNT + 3;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       pi = 1'b0, pq = 1'b0, en = 1'b1;
  logic       up, dn, err, dir, ready;
  logic [7:0] err_cnt;

  int compared = 0, mismatched = 0;
  int n_up, n_dn, n_err;
  int first_up, first_dn, first_err, first_rdy;

  qe_input_decode #(.FILT_CNT(FILT_CNT), .FILT_W(4)) dut (
    .clk_i(clk), .clr_i(clr), .i_i(pi), .q_i(pq), .en_i(en),
    .up_o(up), .dn_o(dn), .err_o(err), .dir_o(dir), .ready_o(ready), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once FILT_CNT edges have passed since the
  // last edge whose synced sample matched the current filtered level.
  bit [1:0] m_s1, m_s2, m_filt, m_prev;
  int       last_eq [2];
  int       cyc = 0, since = 0, m_cnt = 0;
  bit       m_rdy, m_up, m_dn, m_err, m_dir;

  function automatic int gidx(input bit [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_s1 = 0; m_s2 = 0; m_filt = 0; m_prev = 0;
      last_eq[0] = cyc; last_eq[1] = cyc;
      since = 0; m_cnt = 0;
      m_rdy = 0; m_up = 0; m_dn = 0; m_err = 0; m_dir = 0;
    end else begin
      int  d;
      bit  g;
      cyc++;
      d     = (gidx(m_filt) - gidx(m_prev) + 4) % 4;
      g     = m_rdy && en;
      m_up  = g && d == 1;
      m_dn  = g && d == 3;
      m_err = g && d == 2;
      if (m_up) m_dir = 1;
      if (m_dn) m_dir = 0;
      if (m_err && m_cnt < 255) m_cnt++;
      m_prev = m_filt;
      for (int ch = 0; ch < 2; ch++) begin
        if (m_s2[ch] == m_filt[ch]) last_eq[ch] = cyc;
        else if (cyc - last_eq[ch] >= FILT_CNT) begin
          m_filt[ch]  = m_s2[ch];
          last_eq[ch] = cyc;
        end
      end
      m_s2 = m_s1;
      m_s1 = {pi, pq};
      if (since < SETTLE) since++;
      m_rdy = since >= SETTLE;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic clear_counts();
    n_up = 0; n_dn = 0; n_err = 0;
  endtask

  // Run n cycles, checking every output against the model at each falling edge.
  task automatic hold(input int n);
    first_up = -1; first_dn = -1; first_err = -1; first_rdy = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk("up", up, m_up);
      chk("dn", dn, m_dn);
      chk("err", err, m_err);
      chk("dir", dir, m_dir);
      chk("ready", ready, m_rdy);
      chk("err_cnt", err_cnt, m_cnt);
      chk("excl", up + dn + err <= 1, 1);
      n_up += up; n_dn += dn; n_err += err;
      if (up && first_up < 0) first_up = k;
      if (dn && first_dn < 0) first_dn = k;
      if (err && first_err < 0) first_err = k;
      if (ready && first_rdy < 0) first_rdy = k;
    end
  endtask

  task automatic pins(input bit [1:0] v);
    {pi, pq} = v;
  endtask

  initial begin
    bit [1:0] fwd [4];
    bit [1:0] rev [4];
    fwd = '{2'b10, 2'b11, 2'b01, 2'b00};
    rev = '{2'b01, 2'b11, 2'b10, 2'b00};

    // 1: reset with pins at 11, settle timing, no pulses
    pins(2'b11);
    #1 clr = 1'b1;
    clear_counts();
    hold(3);
    chk("rst_ready", ready, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_dir", dir, 0);
    clr = 1'b0;
    hold(15);
    chk("settle_at", first_rdy, SETTLE);
    chk("settle_quiet", n_up + n_dn + n_err, 0);

    pins(2'b01); hold(20);
    pins(2'b00); hold(20);

    // 2: forward sequence
    clear_counts();
    for (int s = 0; s < 4; s++) begin
      pins(fwd[s]); hold(20);
      chk("fwd_lat", first_up, 11);
    end
    chk("fwd_nup", n_up, 4);
    chk("fwd_ndn", n_dn, 0);
    chk("fwd_dir", dir, 1);

    // 3: reverse sequence
    clear_counts();
    for (int s = 0; s < 4; s++) begin
      pins(rev[s]); hold(20);
      chk("rev_lat", first_dn, 11);
    end
    chk("rev_ndn", n_dn, 4);
    chk("rev_nup", n_up, 0);
    chk("rev_dir", dir, 0);
    chk("rev_errcnt", err_cnt, 0);

    // 4: glitch rejection at 7, acceptance at 8
    clear_counts();
    pins(2'b10); hold(7);
    pins(2'b00); hold(20);
    chk("glitch7", n_up + n_dn + n_err, 0);
    pins(2'b10); hold(8);
    pins(2'b00); hold(20);
    chk("pulse8_up_at", first_up, 3);
    chk("pulse8_dn_at", first_dn, 11);
    chk("pulse8_n", n_up + n_dn, 2);

    // 5: simultaneous change -> err, then saturation
    clear_counts();
    pins(2'b11); hold(20);
    chk("err_at", first_err, 11);
    chk("err_cnt1", err_cnt, 1);
    chk("err_nostep", n_up + n_dn, 0);
    chk("err_dir", dir, 0);
    for (int r = 1; r < 300; r++) begin
      pins((r % 2) ? 2'b00 : 2'b11); hold(12);
    end
    chk("err_n", n_err, 300);
    chk("err_sat", err_cnt, 255);

    // 6: enable gating, no catch-up
    clear_counts();
    en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      pins(fwd[s]); hold(20);
    end
    en = 1'b1;
    hold(20);
    chk("en_quiet", n_up + n_dn + n_err, 0);
    pins(2'b00); hold(20);
    chk("en_single", n_up, 1);
    chk("en_lat", first_up, 11);

    // clr landing while a pulse is high
    pins(2'b10); hold(10);
    @(posedge clk); #1;
    chk("pre_clr_up", up, 1);
    clr = 1'b1; #1;
    chk("clr_up", up, 0);
    chk("clr_dir", dir, 0);
    chk("clr_ready", ready, 0);
    chk("clr_errcnt", err_cnt, 0);
    hold(2);
    clr = 1'b0;
    hold(15);
    chk("resettle_at", first_rdy, SETTLE);

    // random traffic
    for (int r = 0; r < 250; r++) begin
      pins(2'($urandom_range(0, 3)));
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        clr = 1'b1; hold(2); clr = 1'b0;
      end
      hold($urandom_range(1, 14));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
